ahb2apb_bridge: RTL and testbench

- AHB-Lite slave to APB master bridge; sits directly upstream of the APB decoder/mux and drives its PADDR/PSEL/PENABLE/PWRITE/PWDATA inputs.
- Consumes the mux's PRDATA/PREADY/PSLVERR.
- Converts each AHB single transfer into one APB SETUP/ACCESS pair, inserting AHB wait states.
- Maps APB errors, illegal sizes and APB timeouts onto a two-cycle AHB ERROR response.

---
 rtl/ahb2apb_bridge.sv | 76 +++++++
 tb/tb_ahb2apb_bridge.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to APB master bridge, one APB SETUP/ACCESS pair per AHB
// single transfer, with APB errors, illegal sizes and ACCESS timeouts reported as AHB ERROR.
module ahb2apb_bridge #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);
    typedef enum logic [2:0] {IDLE, LATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t      state, next;
    logic [15:0] cnt;
    logic        acc, timeout_hit;

    assign acc         = HSEL & HREADY & (HTRANS inside {2'b10, 2'b11});
    assign timeout_hit = (TIMEOUT != 16'd0) && (cnt == TIMEOUT - 16'd1);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= IDLE;
        else        state <= next;
    end

    // H*/P* control outputs are pure decodes of the state register
    always_comb begin
        next      = state;
        HREADYOUT = (state == IDLE) || (state == ERR2);
        HRESP     = (state == ERR1) || (state == ERR2);
        PSEL      = (state == SETUP) || (state == ACCESS);
        PENABLE   = (state == ACCESS);
        case (state)
            IDLE, ERR2: next = !acc ? IDLE : (HSIZE <= 3'b010) ? LATCH : ERR1;
            LATCH:      next = SETUP;
            SETUP:      next = ACCESS;
            ACCESS:     next = PREADY ? (PSLVERR ? ERR1 : IDLE) : (timeout_hit ? ERR1 : ACCESS);
            ERR1:       next = ERR2;
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            HRDATA <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            cnt    <= '0;
        end else begin
            if (next == LATCH) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            if (state == LATCH) PWDATA <= HWDATA;
            if (state == SETUP) cnt <= '0;
            else if (state == ACCESS && !PREADY) cnt <= cnt + 16'd1;
            if (state == ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
        end
    end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed and random AHB transfers against a per-transfer outcome model,
// with a reactive APB slave; a second instance with TIMEOUT=0 covers the no-timeout case.
module tb_ahb2apb_bridge;
    localparam logic [15:0] TO = 16'd4;

    logic        HCLK = 0, HRESET = 1, HSEL = 0, HWRITE = 0, HREADY = 1;
    logic [31:0] HADDR = 0, HWDATA = 0, PRDATA = 0;
    logic [1:0]  HTRANS = 0;
    logic [2:0]  HSIZE = 0;
    logic        PREADY = 0, PSLVERR = 0;
    logic [31:0] HRDATA, PADDR, PWDATA;
    logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE;
    logic [31:0] hrdata_z, paddr_z, pwdata_z;
    logic        hreadyout_z, hresp_z, psel_z, penable_z, pwrite_z;

    int          checks = 0, passed = 0;
    logic [31:0] model_hrdata = 0;

    always #5 HCLK = ~HCLK;

    ahb2apb_bridge #(.TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .PADDR(PADDR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    ahb2apb_bridge #(.TIMEOUT(16'd0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(hrdata_z), .HREADYOUT(hreadyout_z), .HRESP(hresp_z), .PADDR(paddr_z),
        .PSEL(psel_z), .PENABLE(penable_z), .PWRITE(pwrite_z), .PWDATA(pwdata_z),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [2:0] size);
        HSEL = 1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size; HREADY = 1;
        tick;
        HSEL = 0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom);
    endtask

    // Entered in the cycle where the previous data phase completes; that cycle is the
    // address phase, so consecutive calls are back-to-back transfers.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [31:0] wdata, input int nwait,
                        input logic err, input logic [31:0] rdata);
        bit legal   = size <= 3'd2;
        bit tout    = legal && nwait >= int'(TO);
        int exp_acc = !legal ? 0 : tout ? int'(TO) : nwait + 1;
        bit exp_err = !legal || tout || err;
        int exp_w   = !legal ? 1 : 2 + exp_acc + int'(exp_err);
        int waits = 0, accs = 0, setups = 0, setup_at = -1, resp_low = 0, cyc = 1;
        bit bad_apb = 0;
        addr_phase(addr, wr, size);
        HWDATA = wdata;
        while (!HREADYOUT && waits < 200) begin
            waits++;
            if (HRESP) resp_low++;
            if (PSEL && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata)) bad_apb = 1;
            if (PSEL && !PENABLE) begin
                setups++;
                setup_at = cyc;
            end
            if (PSEL && PENABLE) begin
                PREADY = accs >= nwait; PSLVERR = err; PRDATA = rdata;
                accs++;
            end else begin
                PREADY = 0; PSLVERR = 0; PRDATA = $urandom;
            end
            tick;
            cyc++;
        end
        PREADY = 0; PSLVERR = 0; HWDATA = $urandom;
        if (!exp_err && !wr) model_hrdata = rdata;
        check({tag, ".waits"}, waits, exp_w);
        check({tag, ".access_cycles"}, accs, exp_acc);
        check({tag, ".setups"}, setups, legal ? 1 : 0);
        check({tag, ".setup_at"}, setup_at, legal ? 2 : -1);
        check({tag, ".apb_fields"}, bad_apb, 0);
        check({tag, ".resp_while_wait"}, resp_low, exp_err ? 1 : 0);
        check({tag, ".hresp"}, HRESP, exp_err);
        check({tag, ".hrdata"}, HRDATA, model_hrdata);
        check({tag, ".psel_end"}, PSEL, 0);
    endtask

    initial begin
        int n;
        logic [2:0] sz;
        tick;
        tick;
        check("rst.hreadyout", HREADYOUT, 1);
        check("rst.hresp", HRESP, 0);
        check("rst.psel", PSEL, 0);
        check("rst.penable", PENABLE, 0);
        check("rst.paddr", PADDR, 0);
        check("rst.pwdata", PWDATA, 0);
        check("rst.pwrite", PWRITE, 0);
        check("rst.hrdata", HRDATA, 0);
        HRESET = 0;
        tick;

        for (int i = 0; i < 3; i++) begin
            HSEL = 1; HTRANS = (i == 1) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00; HREADY = (i != 2);
            tick;
            check("ignored.psel", PSEL, 0);
            check("ignored.hreadyout", HREADYOUT, 1);
        end
        HSEL = 0; HTRANS = 0; HREADY = 1;
        tick;

        xfer("write", 32'h0000_1004, 1, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'h0);
        xfer("read_wait", 32'h0000_2000, 0, 3'b010, 32'h0, 2, 0, 32'h1234_5678);
        xfer("slverr", 32'h0000_3000, 0, 3'b010, 32'h0, 0, 1, 32'hAAAA_5555);
        xfer("bad_size", 32'h0000_4000, 1, 3'b011, 32'h1111_2222, 0, 0, 32'h0);
        xfer("timeout", 32'h0000_5000, 0, 3'b010, 32'h0, 10, 0, 32'h7777_7777);
        xfer("b2b_wr", 32'h0000_6000, 1, 3'b001, 32'hCAFE_0001, 0, 0, 32'h0);
        xfer("b2b_rd", 32'h0000_6004, 0, 3'b000, 32'h0, 0, 0, 32'h0BAD_F00D);

        for (int i = 0; i < 40; i++) begin
            sz = ($urandom % 5 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            xfer("rand", $urandom, 1'($urandom), sz, $urandom, $urandom_range(0, 5),
                 ($urandom % 5 == 0), $urandom);
        end

        HRESET = 1;
        tick;
        HRESET = 0;
        model_hrdata = 0;
        tick;
        addr_phase(32'h0000_7000, 0, 3'b010);
        PREADY = 0;
        tick;
        tick;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (psel_z && penable_z) n++;
            tick;
        end
        check("no_timeout.access_cycles", n, 1000);
        check("no_timeout.hreadyout", hreadyout_z, 0);
        PREADY = 1; PRDATA = 32'h5A5A_A5A5;
        tick;
        PREADY = 0;
        check("no_timeout.done", hreadyout_z, 1);
        check("no_timeout.hresp", hresp_z, 0);
        check("no_timeout.hrdata", hrdata_z, 32'h5A5A_A5A5);

        addr_phase(32'h0000_8000, 1, 3'b010);
        tick;
        tick;
        check("mid_rst.in_access", PENABLE, 1);
        #2 HRESET = 1;
        #1;
        check("mid_rst.psel", PSEL, 0);
        check("mid_rst.penable", PENABLE, 0);
        check("mid_rst.hreadyout", HREADYOUT, 1);
        check("mid_rst.hresp", HRESP, 0);
        check("mid_rst.paddr", PADDR, 0);
        #1 HRESET = 0;
        tick;
        check("post_rst.hreadyout", HREADYOUT, 1);
        check("post_rst.psel", PSEL, 0);
        check("post_rst.hrdata", HRDATA, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
